// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, device-clock fall indices
// and microsecond-to-cycle conversion helpers.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_REQ,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ERROR
  } state_e;

  // Device clock falling-edge numbers within one host-to-device frame
  localparam logic [3:0] LAST_DATA   = 4'd8;
  localparam logic [3:0] PARITY_FALL = 4'd9;
  localparam logic [3:0] STOP_FALL   = 4'd10;
  localparam logic [3:0] ACK_FALL    = 4'd11;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  // Width of a counter that runs 0 .. n-1
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status handshake and PS/2 pin signals of the host transmitter.
interface ps2_host_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport slave (
    input  tx_start, tx_data, ps2c_in, ps2d_in,
    output ps2c_oe, ps2d_oe, busy, tx_done, tx_err
  );

  modport master (
    output tx_start, tx_data, ps2c_in, ps2d_in,
    input  ps2c_oe, ps2d_oe, busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_sync.sv
// Two-flop synchronisers for the PS/2 clock and data pins plus a
// falling-edge detector on the synchronised clock. Shared with the receiver.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic ps2c_o,
  output logic ps2d_o,
  output logic fall_o
);

  logic [1:0] c_q;
  logic [1:0] d_q;
  logic       c_prev_q;

  // Synchroniser chains reset to the idle (pulled-up) level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q      <= '1;
      d_q      <= '1;
      c_prev_q <= 1'b1;
    end else begin
      c_q      <= {c_q[0], ps2c_i};
      d_q      <= {d_q[0], ps2d_i};
      c_prev_q <= c_q[1];
    end
  end

  assign ps2c_o = c_q[1];
  assign ps2d_o = d_q[1];
  assign fall_o = c_prev_q & ~c_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// byte with odd parity on device clock falls, check the device ACK.
// Optional macro PS2_HOST_TX_RETRY_EN: one silent retry after NACK/timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input logic          clk,
  input logic          rst,
  ps2_host_tx_if.slave bus
);

  localparam int unsigned INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int unsigned INH_W = cnt_width(INHIBIT_CYCLES);
  localparam int unsigned WD_W  = cnt_width(TIMEOUT_CYCLES);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             dout_q, dout_d;
  logic             c_oe_q, c_oe_d;
  logic             d_oe_q, d_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fail;
`ifdef PS2_HOST_TX_RETRY_EN
  logic             retry_q, retry_d;
`endif

  logic c_s, d_s, fall;

  ps2_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .ps2c_i (bus.ps2c_in),
    .ps2d_i (bus.ps2d_in),
    .ps2c_o (c_s),
    .ps2d_o (d_s),
    .fall_o (fall)
  );

  // State, counters and registered pin/status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      inh_q   <= '0;
      wd_q    <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      inh_q   <= inh_d;
      wd_q    <= wd_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      c_oe_q  <= c_oe_d;
      d_oe_q  <= d_oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  // Next-state logic; outputs are derived from the next state so they are
  // registered yet change in the same cycle as the state they describe.
  always_comb begin
    state_d = state_q;
    inh_d   = inh_q;
    wd_d    = wd_q;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    fail    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_d = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d = 1'b0;
`endif
        if (bus.tx_start) begin
          data_d  = bus.tx_data;
          par_d   = ~^bus.tx_data;
          inh_d   = '0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          inh_d   = '0;
          state_d = ST_START;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      ST_START: begin
        wd_d    = '0;
        bit_d   = '0;
        dout_d  = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ, ST_DATA: begin
        if (fall) begin
          wd_d    = '0;
          bit_d   = bit_q + 1'b1;
          state_d = ST_DATA;
          if (bit_d <= LAST_DATA) begin
            dout_d = ~data_q[bit_q[2:0]];
          end else if (bit_d == PARITY_FALL) begin
            dout_d = ~par_q;
          end else begin
            dout_d  = 1'b0;
            state_d = ST_ACK;
          end
        end else if (wd_q == WD_LAST) begin
          fail = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_ACK: begin
        if (fall) begin
          wd_d  = '0;
          bit_d = ACK_FALL;
          if (d_s) fail = 1'b1;
          else     state_d = ST_WAIT_IDLE;
        end else if (wd_q == WD_LAST) begin
          fail = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (c_s && d_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (fall) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          fail = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail) begin
      dout_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        inh_d   = '0;
        state_d = ST_INHIBIT;
      end else begin
        state_d = ST_ERROR;
      end
`else
      state_d = ST_ERROR;
`endif
    end

    c_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_START);
    d_oe_d = (state_d == ST_START) ||
             (((state_d == ST_REQ) || (state_d == ST_DATA) || (state_d == ST_ACK)) && dout_d);
    busy_d = !((state_d == ST_IDLE) || (state_d == ST_ERROR));
    err_d  = (state_d == ST_ERROR);
  end

  assign bus.ps2c_oe = c_oe_q;
  assign bus.ps2d_oe = d_oe_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;
  assign bus.tx_err  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a 12.5 kHz keyboard model on wired-AND pins,
// a frame scoreboard and a table of transfer scenarios.
module tb_ps2_host_tx;

  localparam int HALF = 40;     // keyboard half period in system clocks
  localparam int TO   = 2000;   // watchdog limit in system clocks
  localparam int M_OK = 0, M_NACK = 1, M_STALL = 2;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    int         mode;
    bit         glitch;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kc = 1'b1;
  logic kd = 1'b1;
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, cyc = 0;
  int inh_run = 0, start_run = 0, last_inh = 0, last_start = 0;
  logic busy_prev = 1'b0;
  logic [10:0] sb[$];
  vec_t vecs[7];

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .CLK_FREQ_HZ (1_000_000),
    .INHIBIT_US  (100),
    .TIMEOUT_US  (2000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.ps2c_in = kc & ~bus.ps2c_oe;
  assign bus.ps2d_in = kd & ~bus.ps2d_oe;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // Pulse counting, pulse-exclusivity and inhibit/start phase lengths
  always @(negedge clk) begin
    if (rst) begin
      if (bus.tx_done) done_cnt++;
      if (bus.tx_err) err_cnt++;
      if (bus.tx_done || bus.tx_err)
        chk("done_err_exclusive", {31'd0, bus.tx_done & bus.tx_err}, 0);
      if (bus.tx_done)
        chk("busy_falls_with_done", {30'd0, busy_prev, bus.busy}, 2'b10);
      if (bus.ps2c_oe && !bus.ps2d_oe) inh_run++;
      else if (inh_run != 0) begin last_inh = inh_run; inh_run = 0; end
      if (bus.ps2c_oe && bus.ps2d_oe) start_run++;
      else if (start_run != 0) begin last_start = start_run; start_run = 0; end
    end else begin
      inh_run = 0;
      start_run = 0;
    end
    busy_prev = bus.busy;
  end

  // Keyboard model for one attempt: sample the frame, then ACK, NACK or stall
  task automatic device(input int mode, input bit glitch);
    logic [10:0] fr, exp, mask;
    int n, t_last, k;
    fr = '0;
    t_last = cyc;
    for (k = 0; k < 400 && !(bus.busy && !bus.ps2c_oe && bus.ps2d_oe); k++) @(negedge clk);
    chk("request_seen", {31'd0, k < 400}, 1);
    if (k >= 400) return;
    repeat (5) @(negedge clk);
    chk("inhibit_len", last_inh, 100);
    chk("start_len", last_start, 1);
    fr[0] = bus.ps2d_in;
    repeat (HALF) @(negedge clk);
    n = (mode == M_STALL) ? 4 : 10;
    for (int i = 1; i <= n; i++) begin
      if (glitch && i == 4) begin
        bus.tx_data = 8'h00;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
      end
      kc = 1'b0;
      t_last = cyc;
      repeat (HALF) @(negedge clk);
      kc = 1'b1;
      fr[i] = bus.ps2d_in;
      repeat (HALF) @(negedge clk);
    end
    mask = (mode == M_STALL) ? 11'h01F : 11'h7FF;
    if (sb.size() == 0) begin
      chk("scoreboard_has_entry", 0, 1);
    end else begin
      exp = sb.pop_front();
      chk("frame", {21'd0, fr & mask}, {21'd0, exp & mask});
    end
    if (mode == M_STALL) begin
      for (k = 0; k < 2500 && !(bus.tx_err || bus.ps2c_oe); k++) @(negedge clk);
      chk("timeout_seen", {31'd0, k < 2500}, 1);
      // limit plus two synchroniser stages and the output register
      chk_range("timeout_delay", cyc - t_last, TO, TO + 4);
      if (bus.tx_err) chk("err_lines_released", {30'd0, bus.ps2c_oe, bus.ps2d_oe}, 0);
    end else begin
      kd = (mode == M_OK) ? 1'b0 : 1'b1;
      repeat (5) @(negedge clk);
      kc = 1'b0;
      repeat (HALF) @(negedge clk);
      kc = 1'b1;
      kd = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int attempts, d0, e0, k, m;
    attempts = (v.mode != M_OK && RETRY) ? 2 : 1;
    for (int a = 0; a < attempts; a++) sb.push_back(mk_frame(v.data));
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    bus.tx_data = v.data;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_data = 8'($urandom);
    for (int a = 0; a < attempts; a++) begin
      m = (a == 1 && v.mode == M_NACK) ? M_OK : v.mode;
      device(m, v.glitch && a == 0);
    end
    for (k = 0; k < 300 && done_cnt == d0 && err_cnt == e0; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("done_pulses", done_cnt - d0, {31'd0, v.exp_done});
    chk("err_pulses", err_cnt - e0, {31'd0, v.exp_err});
    chk("idle_after", {29'd0, bus.busy, bus.ps2c_oe, bus.ps2d_oe}, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int k;
    vecs[0] = '{8'hED, M_OK,    1'b0, 1'b1,   1'b0};
    vecs[1] = '{8'hF4, M_OK,    1'b0, 1'b1,   1'b0};
    vecs[2] = '{8'hED, M_OK,    1'b1, 1'b1,   1'b0};
    vecs[3] = '{8'h00, M_OK,    1'b0, 1'b1,   1'b0};
    vecs[4] = '{8'hA5, M_STALL, 1'b0, 1'b0,   1'b1};
    vecs[5] = '{8'h3C, M_NACK,  1'b0, RETRY,  !RETRY};
    vecs[6] = '{8'hFF, M_OK,    1'b0, 1'b1,   1'b0};

    bus.tx_start = 1'b0;
    bus.tx_data = 8'h00;
    #2 rst = 1'b0;

    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      kc = 1'($urandom);
      kd = 1'($urandom);
      bus.tx_start = 1'($urandom);
      bus.tx_data = 8'($urandom);
      #1;
      if ({bus.ps2c_oe, bus.ps2d_oe, bus.busy, bus.tx_done, bus.tx_err} !== 5'b0) ok = 1'b0;
    end
    chk("reset_outputs_zero", {31'd0, ok}, 1);

    @(negedge clk);
    kc = 1'b1;
    kd = 1'b1;
    bus.tx_start = 1'b0;
    rst = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i % HALF == 0 && i < 800) kc = ~kc;
      if ({bus.ps2c_oe, bus.ps2d_oe, bus.busy, bus.tx_done, bus.tx_err} !== 5'b0) ok = 1'b0;
    end
    kc = 1'b1;
    chk("idle_quiet_1000", {31'd0, ok}, 1);
    repeat (HALF) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      repeat (50) @(negedge clk);
    end
    chk("scoreboard_drained", sb.size(), 0);

    // Asynchronous reset while the host is driving a data bit low
    @(negedge clk);
    bus.tx_data = 8'hED;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    for (k = 0; k < 400 && !(bus.busy && !bus.ps2c_oe && bus.ps2d_oe); k++) @(negedge clk);
    chk("mid_reset_request_seen", {31'd0, k < 400}, 1);
    repeat (HALF) @(negedge clk);
    kc = 1'b0;
    repeat (HALF) @(negedge clk);
    kc = 1'b1;
    repeat (HALF) @(negedge clk);
    kc = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_reset_driving", {30'd0, bus.busy, bus.ps2d_oe}, 2'b11);
    #2 rst = 1'b0;
    #1 chk("reset_releases_lines", {29'd0, bus.ps2c_oe, bus.ps2d_oe, bus.busy}, 0);
    kc = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (HALF) @(negedge clk);

    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
